// File: rtl/alu_hs_if.sv
// Operand/result handshake bundle for alu_hs.
// The master side issues ops and takes results; the slave side is the ALU.
interface alu_hs_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             taken;
    logic             carry;
    logic             ovf;
    logic             illegal;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, taken, carry, ovf, illegal
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, taken, carry, ovf, illegal
    );
endinterface

// File: rtl/alu_hs.sv
// Handshaked ALU: single-cycle add/sub/parity/compare/logic/shift ops and an
// iterative shift-add multiply, with one registered result slot whose result,
// branch flag and status bits are written together on every completed op.
// WIDTH must be even and >= 4; SHW must satisfy 2**SHW <= WIDTH.
module alu_hs #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic     clk,
    input  logic     rst,
    alu_hs_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam int HALF  = WIDTH / 2;

    localparam logic [3:0] OP_ADD     = 4'd0;
    localparam logic [3:0] OP_SUB     = 4'd1;
    localparam logic [3:0] OP_EVEN_UP = 4'd2;
    localparam logic [3:0] OP_EVEN_LO = 4'd3;
    localparam logic [3:0] OP_GTE     = 4'd4;
    localparam logic [3:0] OP_LTZ     = 4'd5;
    localparam logic [3:0] OP_EZ      = 4'd6;
    localparam logic [3:0] OP_EQ      = 4'd7;
    localparam logic [3:0] OP_NE      = 4'd8;
    localparam logic [3:0] OP_AND     = 4'd9;
    localparam logic [3:0] OP_OR      = 4'd10;
    localparam logic [3:0] OP_XOR     = 4'd11;
    localparam logic [3:0] OP_SLL     = 4'd12;
    localparam logic [3:0] OP_SRL     = 4'd13;
    localparam logic [3:0] OP_MUL     = 4'd14;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    // Control and output registers
    state_t           state_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             taken_q;
    logic             carry_q;
    logic             ovf_q;
    logic             illegal_q;

    // Multiplier working registers
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;

    // Next values for single-cycle ops and the multiply step
    logic [WIDTH-1:0] result_d;
    logic             taken_d;
    logic             carry_d;
    logic             ovf_d;
    logic             illegal_d;
    logic [WIDTH-1:0] acc_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             in_ready;
    logic             accept;
    logic             consume;
    logic             mul_done;

    // A new op may enter only when idle and the result slot is empty or
    // being drained this same edge.
    assign in_ready = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign consume  = out_valid_q && bus.out_ready;
    assign mul_done = (state_q == S_MUL) && (cnt_q == CNT_W'(WIDTH - 1));

    // Extra top bit carries the ADD carry-out and the SUB borrow.
    assign sum  = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff = {1'b0, bus.a} - {1'b0, bus.b};

    // Partial product for the current multiplier bit.
    assign acc_d = acc_q + (b_sh_q[0] ? a_sh_q : '0);

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.taken     = taken_q;
    assign bus.carry     = carry_q;
    assign bus.ovf       = ovf_q;
    assign bus.illegal   = illegal_q;

    // Decode the single-cycle ops into the full set of output values.
    always_comb begin
        // NOTE: every output gets a default first, so no op path can leave
        // a variable unassigned and infer a latch.
        result_d  = '0;
        taken_d   = 1'b0;
        carry_d   = 1'b0;
        ovf_d     = 1'b0;
        illegal_d = 1'b0;
        case (bus.op)
            OP_ADD: begin
                result_d = sum[WIDTH-1:0];
                carry_d  = sum[WIDTH];
                ovf_d    = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                           (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                result_d = diff[WIDTH-1:0];
                carry_d  = !diff[WIDTH];
                ovf_d    = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                           (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_EVEN_UP: result_d[0] = ~^bus.a[WIDTH-1:HALF];
            OP_EVEN_LO: result_d[0] = ~^bus.a[HALF-1:0];
            OP_GTE:     taken_d     = !diff[WIDTH];
            OP_LTZ:     taken_d     = bus.a[WIDTH-1];
            OP_EZ:      taken_d     = (bus.a == '0);
            OP_EQ:      taken_d     = (bus.a == bus.b);
            OP_NE:      taken_d     = (bus.a != bus.b);
            OP_AND:     result_d    = bus.a & bus.b;
            OP_OR:      result_d    = bus.a | bus.b;
            OP_XOR:     result_d    = bus.a ^ bus.b;
            OP_SLL:     result_d    = bus.a << bus.b[SHW-1:0];
            OP_SRL:     result_d    = bus.a >> bus.b[SHW-1:0];
            OP_MUL:     ; // produced by the multiply FSM
            default:    illegal_d   = 1'b1; // only op 15 lands here
        endcase
    end

    // Handshake, result slot and shift-add multiply sequencing.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // values from before this edge, independent of statement order.
        if (rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            taken_q     <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            illegal_q   <= 1'b0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept && (bus.op == OP_MUL)) begin
                        // Accept implies any previous result leaves this edge.
                        state_q     <= S_MUL;
                        out_valid_q <= 1'b0;
                        a_sh_q      <= bus.a;
                        b_sh_q      <= bus.b;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                    end else if (accept) begin
                        out_valid_q <= 1'b1;
                        result_q    <= result_d;
                        taken_q     <= taken_d;
                        carry_q     <= carry_d;
                        ovf_q       <= ovf_d;
                        illegal_q   <= illegal_d;
                    end else if (consume) begin
                        out_valid_q <= 1'b0;
                    end
                end
                S_MUL: begin
                    acc_q  <= acc_d;
                    a_sh_q <= a_sh_q << 1;
                    b_sh_q <= b_sh_q >> 1;
                    cnt_q  <= cnt_q + 1'b1;
                    if (mul_done) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b1;
                        result_q    <= acc_d;
                        taken_q     <= 1'b0;
                        carry_q     <= 1'b0;
                        ovf_q       <= 1'b0;
                        illegal_q   <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_hs.sv
// Self-checking bench for alu_hs: directed handshake/latency cases followed by
// randomized traffic scored against an arithmetic reference model.
module tb_alu_hs;
    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] result;
        logic         taken;
        logic         carry;
        logic         ovf;
        logic         illegal;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    exp_t exp_q[$];

    alu_hs_if #(.WIDTH(W)) bus ();

    alu_hs #(.WIDTH(W), .SHW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference behaviour from plain integer arithmetic.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint ua, ub, sa, sb, t;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e  = '0;
        case (op)
            4'd0: begin
                t = ua + ub;  e.result = t[W-1:0];  e.carry = (t > 65535);
                t = sa + sb;  e.ovf = (t > 32767) || (t < -32768);
            end
            4'd1: begin
                t = ua - ub;  e.result = t[W-1:0];  e.carry = (ua >= ub);
                t = sa - sb;  e.ovf = (t > 32767) || (t < -32768);
            end
            4'd2:  e.result = ($countones(a[15:8]) % 2 == 0) ? 16'd1 : 16'd0;
            4'd3:  e.result = ($countones(a[7:0]) % 2 == 0) ? 16'd1 : 16'd0;
            4'd4:  e.taken = (ua >= ub);
            4'd5:  e.taken = (sa < 0);
            4'd6:  e.taken = (ua == 0);
            4'd7:  e.taken = (ua == ub);
            4'd8:  e.taken = (ua != ub);
            4'd9:  e.result = a & b;
            4'd10: e.result = a | b;
            4'd11: e.result = a ^ b;
            4'd12: e.result = a << b[3:0];
            4'd13: e.result = a >> b[3:0];
            4'd14: begin t = ua * ub; e.result = t[W-1:0]; end
            default: e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    task automatic check_fields(input string tag, input exp_t e);
        check({tag, "_valid"},   bus.out_valid, 1'b1);
        check({tag, "_result"},  bus.result,    e.result);
        check({tag, "_taken"},   bus.taken,     e.taken);
        check({tag, "_carry"},   bus.carry,     e.carry);
        check({tag, "_ovf"},     bus.ovf,       e.ovf);
        check({tag, "_illegal"}, bus.illegal,   e.illegal);
    endtask

    // Issue one op at a negedge with out_ready high, wait for its result.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        int lat;
        n = 0;
        while (!bus.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rdy"}, bus.in_ready, 1'b1);
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a  = a;
        bus.b  = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            check({tag, "_busy"}, bus.in_ready, 1'b0);
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, lat, (op == 4'd14) ? W : 0);
        check_fields(tag, model(op, a, b));
    endtask

    initial begin
        int   seen;
        int   n;
        exp_t e;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.op = '0;
        bus.a  = '0;
        bus.b  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid",   bus.out_valid, 1'b0);
        check("rst_result",  bus.result,    16'h0);
        check("rst_taken",   bus.taken,     1'b0);
        check("rst_carry",   bus.carry,     1'b0);
        check("rst_ovf",     bus.ovf,       1'b0);
        check("rst_illegal", bus.illegal,   1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", bus.in_ready, 1'b1);

        // Directed ops
        run_op("add", 4'd0, 16'h7FFF, 16'h0001);
        check("add_lit", {bus.result, bus.carry, bus.ovf}, {16'h8000, 1'b0, 1'b1});

        // SUB followed one cycle later by EQ
        bus.in_valid = 1'b1;
        bus.op = 4'd1; bus.a = 16'd3; bus.b = 16'd5;
        @(negedge clk);
        check_fields("sub", model(4'd1, 16'd3, 16'd5));
        check("sub_lit", {bus.result, bus.carry, bus.ovf}, {16'hFFFE, 1'b0, 1'b0});
        check("b2b_ready", bus.in_ready, 1'b1);
        bus.op = 4'd7; bus.a = 16'h1234; bus.b = 16'h1234;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_fields("eq", model(4'd7, 16'h1234, 16'h1234));
        check("eq_lit", {bus.result, bus.taken}, {16'h0, 1'b1});

        run_op("even_up", 4'd2, 16'h0300, 16'h0);
        check("even_up_lit", bus.result, 16'd1);
        run_op("even_lo", 4'd3, 16'h0001, 16'h0);
        check("even_lo_lit", bus.result, 16'd0);
        run_op("ltz", 4'd5, 16'h8000, 16'h0);
        check("ltz_lit", bus.taken, 1'b1);
        run_op("sll", 4'd12, 16'h00F1, 16'h0004);
        run_op("srl", 4'd13, 16'h8F00, 16'h000F);
        run_op("mul", 4'd14, 16'd123, 16'd45);
        check("mul_lit", bus.result, 16'd5535);

        // Backpressure: result held, extra in_valid ignored
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.op = 4'd0; bus.a = 16'd1; bus.b = 16'd1;
        @(negedge clk);
        check("bp_first", bus.result, 16'd2);
        bus.op = 4'd9; bus.a = 16'hFFFF; bus.b = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_valid",  bus.out_valid, 1'b1);
            check("bp_hold_result", bus.result,    16'd2);
            check("bp_hold_ready",  bus.in_ready,  1'b0);
        end
        bus.out_ready = 1'b1;
        bus.op = 4'd10; bus.a = 16'h00F0; bus.b = 16'h000F;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_fields("bp_or", model(4'd10, 16'h00F0, 16'h000F));
        check("bp_or_lit", bus.result, 16'h00FF);
        @(negedge clk);
        check("bp_no_queue", bus.out_valid, 1'b0);

        // Reset in the middle of a multiply
        bus.in_valid = 1'b1;
        bus.op = 4'd14; bus.a = 16'd77; bus.b = 16'd99;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_valid",  bus.out_valid, 1'b0);
        check("mrst_result", bus.result,    16'h0);
        check("mrst_ready",  bus.in_ready,  1'b1);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("mrst_lost", seen, 0);

        run_op("ill", 4'd15, 16'hABCD, 16'h1234);
        check("ill_lit", {bus.result, bus.illegal}, {16'h0, 1'b1});
        @(negedge clk);

        // Randomized traffic against the scoreboard
        for (int cyc = 0; cyc < 600; cyc++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_valid  = ($urandom_range(0, 2) != 0);
            bus.op = 4'($urandom_range(0, 15));
            bus.a  = 16'($urandom);
            bus.b  = 16'($urandom);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                check("rnd_pending", (exp_q.size() != 0), 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_fields("rnd", e);
                end
            end
            if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.op, bus.a, bus.b));
            @(negedge clk);
        end

        // Drain what is still in flight
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            #1;
            if (bus.out_valid) begin
                e = exp_q.pop_front();
                check_fields("drain", e);
            end
            @(negedge clk);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
